// File: rtl/lag_fifo_pkg.sv
// Shared types and helpers for the per-VC FIFO bank.
package lag_fifo_pkg;

  // Occupancy-derived status of one virtual channel.
  typedef struct packed {
    logic full;
    logic empty;
    logic nearly_full;
    logic nearly_empty;
  } lag_vc_flags_t;

  // Bit width needed to index n values, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/lag_vc_fifo_bank_chk.sv
// Simulation checks for the FIFO bank: known strobes and bounded occupancy.
module lag_vc_fifo_bank_chk #(
  parameter int NUM_VCS = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     push,
  input logic [NUM_VCS-1:0]       pop,
  input logic [NUM_VCS*CNT_W-1:0] occupancy
);

  // Sample the bank interface once per cycle outside reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(push));
      assert (!$isunknown(pop));
      for (int i = 0; i < NUM_VCS; i++) begin
        assert (occupancy[i*CNT_W +: CNT_W] <= CNT_W'(DEPTH));
      end
    end
  end

endmodule

// File: rtl/lag_vc_fifo_lane.sv
// One virtual-channel FIFO: storage, wrap-around pointers, count, flags and
// sticky error bits. Depth need not be a power of two.
module lag_vc_fifo_lane
  import lag_fifo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = clog2_min1(DEPTH + 1),
  parameter int PTR_W  = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count,
  output lag_vc_flags_t     flags,
  output logic              overflow_err,
  output logic              underflow_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              is_empty;
  logic              is_full;
  logic              do_pop;
  logic              do_push;

  // Advance a pointer with an explicit wrap at the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // Decide which requests take effect; a pop at full frees room for a push.
  always_comb begin
    is_empty = (count == {CNT_W{1'b0}});
    is_full  = (count == CNT_W'(DEPTH));
    do_pop   = rd_en && !is_empty;
    do_push  = wr_en && (!is_full || do_pop);
  end

  // Pointer, count and sticky error state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr        <= {PTR_W{1'b0}};
      wr_ptr        <= {PTR_W{1'b0}};
      count         <= {CNT_W{1'b0}};
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (wr_en && !do_push) begin
        overflow_err <= 1'b1;
      end
      if (rd_en && is_empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

  // Flit storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Head flit and status flags, decoded from registered state only.
  always_comb begin
    if (is_empty) begin
      data_out = {DATA_W{1'b0}};
    end else begin
      data_out = mem[rd_ptr];
    end
    flags.full         = is_full;
    flags.empty        = is_empty;
    flags.nearly_full  = (count == CNT_W'(DEPTH - 1));
    flags.nearly_empty = (count == CNT_W'(1));
  end

endmodule

// File: rtl/lag_vc_fifo_bank.sv
// Bank of independent per-VC FIFOs sharing one write port, each VC with its
// own read strobe, occupancy, flags and sticky error reporting.
module lag_vc_fifo_bank
  import lag_fifo_pkg::*;
#(
  parameter int NUM_VCS = 4,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int VC_W    = clog2_min1(NUM_VCS),
  parameter int CNT_W   = clog2_min1(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [VC_W-1:0]           push_vc,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [NUM_VCS-1:0]        pop,
  output logic [NUM_VCS*DATA_W-1:0] data_out,
  output logic [NUM_VCS-1:0]        full,
  output logic [NUM_VCS-1:0]        empty,
  output logic [NUM_VCS-1:0]        nearly_full,
  output logic [NUM_VCS-1:0]        nearly_empty,
  output logic [NUM_VCS*CNT_W-1:0]  occupancy,
  output logic [NUM_VCS-1:0]        overflow_err,
  output logic [NUM_VCS-1:0]        underflow_err
);

  lag_vc_flags_t lane_flags [NUM_VCS];

  for (genvar i = 0; i < NUM_VCS; i++) begin : g_lane
    logic wr_en;

    // A push_vc beyond the last VC matches no lane and is silently dropped.
    always_comb begin
      wr_en = push && (push_vc == VC_W'(i));
    end

    lag_vc_fifo_lane #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (wr_en),
      .rd_en         (pop[i]),
      .data_in       (data_in),
      .data_out      (data_out[i*DATA_W +: DATA_W]),
      .count         (occupancy[i*CNT_W +: CNT_W]),
      .flags         (lane_flags[i]),
      .overflow_err  (overflow_err[i]),
      .underflow_err (underflow_err[i])
    );

    // Unpack the lane status struct onto the per-VC flag vectors.
    always_comb begin
      full[i]         = lane_flags[i].full;
      empty[i]        = lane_flags[i].empty;
      nearly_full[i]  = lane_flags[i].nearly_full;
      nearly_empty[i] = lane_flags[i].nearly_empty;
    end
  end

  lag_vc_fifo_bank_chk #(
    .NUM_VCS (NUM_VCS),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_lag_vc_fifo_bank.sv
// Self-checking bench: default-size bank driven from a vector table plus a
// scoreboard run, and a 3-VC / depth-3 bank for full, overflow and wrap cases.
module tb_lag_vc_fifo_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance: 4 VCs, depth 4, 32-bit flits.
  logic         a_push;
  logic [1:0]   a_vc;
  logic [31:0]  a_din;
  logic [3:0]   a_pop;
  logic [127:0] a_dout;
  logic [3:0]   a_full, a_empty, a_nf, a_ne, a_ovf, a_unf;
  logic [11:0]  a_occ;

  lag_vc_fifo_bank dut_a (
    .clk(clk), .rst_n(rst_n), .push(a_push), .push_vc(a_vc), .data_in(a_din),
    .pop(a_pop), .data_out(a_dout), .full(a_full), .empty(a_empty),
    .nearly_full(a_nf), .nearly_empty(a_ne), .occupancy(a_occ),
    .overflow_err(a_ovf), .underflow_err(a_unf)
  );

  // Small instance: 3 VCs, depth 3, 32-bit flits.
  logic        b_push;
  logic [1:0]  b_vc;
  logic [31:0] b_din;
  logic [2:0]  b_pop;
  logic [95:0] b_dout;
  logic [2:0]  b_full, b_empty, b_nf, b_ne, b_ovf, b_unf;
  logic [5:0]  b_occ;

  lag_vc_fifo_bank #(.NUM_VCS(3), .DEPTH(3), .DATA_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .push(b_push), .push_vc(b_vc), .data_in(b_din),
    .pop(b_pop), .data_out(b_dout), .full(b_full), .empty(b_empty),
    .nearly_full(b_nf), .nearly_empty(b_ne), .occupancy(b_occ),
    .overflow_err(b_ovf), .underflow_err(b_unf)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] dpack(input int vc, input logic [31:0] v);
    logic [127:0] r;
    r = '0;
    r[vc*32 +: 32] = v;
    return r;
  endfunction

  typedef struct {
    logic         rst_n;
    logic         push;
    logic [1:0]   vc;
    logic [31:0]  din;
    logic [3:0]   pop;
    logic [127:0] dout;
    logic [3:0]   empty, full, nf, ne;
    logic [11:0]  occ;
    logic [3:0]   ovf, unf;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic p, input logic [1:0] vc, input logic [31:0] d,
    input logic [3:0] pp, input logic [127:0] dout, input logic [3:0] em,
    input logic [3:0] fu, input logic [3:0] nf, input logic [3:0] ne,
    input logic [11:0] occ, input logic [3:0] ovf, input logic [3:0] unf);
    vec_t v;
    v.rst_n = r; v.push = p; v.vc = vc; v.din = d; v.pop = pp; v.dout = dout;
    v.empty = em; v.full = fu; v.nf = nf; v.ne = ne; v.occ = occ;
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic b_drive(input logic p, input logic [1:0] vc, input logic [31:0] d, input logic [2:0] pp);
    b_push = p; b_vc = vc; b_din = d; b_pop = pp;
    step();
  endtask

  vec_t vecs[11];
  logic [31:0] sbq[4][$];

  initial begin
    rst_n = 1'b0;
    a_push = 1'b0; a_vc = 2'd0; a_din = 32'h0; a_pop = 4'h0;
    b_push = 1'b0; b_vc = 2'd0; b_din = 32'h0; b_pop = 3'h0;

    //            rst  push vc     din         pop     dout                    empty   full    nf      ne      occ       ovf     unf
    vecs[0]  = mk(1'b0, 1'b0, 2'd0, 32'h0,  4'h0, dpack(0, 32'h0),  4'hF, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0);
    vecs[1]  = mk(1'b1, 1'b0, 2'd0, 32'h0,  4'h0, dpack(0, 32'h0),  4'hF, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0);
    vecs[2]  = mk(1'b1, 1'b1, 2'd2, 32'hA1, 4'h0, dpack(2, 32'hA1), 4'hB, 4'h0, 4'h0, 4'h4, 12'h040, 4'h0, 4'h0);
    vecs[3]  = mk(1'b1, 1'b1, 2'd2, 32'hA2, 4'h0, dpack(2, 32'hA1), 4'hB, 4'h0, 4'h0, 4'h0, 12'h080, 4'h0, 4'h0);
    vecs[4]  = mk(1'b1, 1'b1, 2'd2, 32'hA3, 4'h0, dpack(2, 32'hA1), 4'hB, 4'h0, 4'h4, 4'h0, 12'h0C0, 4'h0, 4'h0);
    vecs[5]  = mk(1'b1, 1'b0, 2'd0, 32'h0,  4'h4, dpack(2, 32'hA2), 4'hB, 4'h0, 4'h0, 4'h0, 12'h080, 4'h0, 4'h0);
    vecs[6]  = mk(1'b1, 1'b0, 2'd0, 32'h0,  4'h4, dpack(2, 32'hA3), 4'hB, 4'h0, 4'h0, 4'h4, 12'h040, 4'h0, 4'h0);
    vecs[7]  = mk(1'b1, 1'b0, 2'd0, 32'h0,  4'h4, dpack(0, 32'h0),  4'hF, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0);
    vecs[8]  = mk(1'b1, 1'b1, 2'd0, 32'h55, 4'h1, dpack(0, 32'h55), 4'hE, 4'h0, 4'h0, 4'h1, 12'h001, 4'h0, 4'h1);
    vecs[9]  = mk(1'b1, 1'b1, 2'd0, 32'h66, 4'h0, dpack(0, 32'h55), 4'hE, 4'h0, 4'h0, 4'h0, 12'h002, 4'h0, 4'h1);
    vecs[10] = mk(1'b0, 1'b0, 2'd0, 32'h0,  4'h0, dpack(0, 32'h0),  4'hF, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0, 4'h0);

    // Table-driven directed vectors on the default bank.
    for (int i = 0; i < 11; i++) begin
      rst_n = vecs[i].rst_n; a_push = vecs[i].push; a_vc = vecs[i].vc;
      a_din = vecs[i].din; a_pop = vecs[i].pop;
      step();
      chk($sformatf("v%0d_dout", i), a_dout, vecs[i].dout);
      chk($sformatf("v%0d_empty", i), {124'h0, a_empty}, {124'h0, vecs[i].empty});
      chk($sformatf("v%0d_full", i), {124'h0, a_full}, {124'h0, vecs[i].full});
      chk($sformatf("v%0d_nf", i), {124'h0, a_nf}, {124'h0, vecs[i].nf});
      chk($sformatf("v%0d_ne", i), {124'h0, a_ne}, {124'h0, vecs[i].ne});
      chk($sformatf("v%0d_occ", i), {116'h0, a_occ}, {116'h0, vecs[i].occ});
      chk($sformatf("v%0d_ovf", i), {124'h0, a_ovf}, {124'h0, vecs[i].ovf});
      chk($sformatf("v%0d_unf", i), {124'h0, a_unf}, {124'h0, vecs[i].unf});
    end
    a_push = 1'b0; a_pop = 4'h0;

    // Depth-3 bank: fill, overflow, push+pop at full across pointer wrap.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("b_reset_empty", {125'h0, b_empty}, {125'h0, 3'b111});
    b_drive(1'b1, 2'd1, 32'hB1, 3'b000);
    b_drive(1'b1, 2'd1, 32'hB2, 3'b000);
    b_drive(1'b1, 2'd1, 32'hB3, 3'b000);
    chk("b_fill_full", {125'h0, b_full}, {125'h0, 3'b010});
    chk("b_fill_occ", {122'h0, b_occ}, {122'h0, 6'h0C});
    chk("b_fill_dout", {32'h0, b_dout}, {32'h0, 32'h0, 32'hB1, 32'h0});
    chk("b_fill_ovf", {125'h0, b_ovf}, {125'h0, 3'b000});
    b_drive(1'b1, 2'd1, 32'hB4, 3'b000);
    chk("b_drop_ovf", {125'h0, b_ovf}, {125'h0, 3'b010});
    chk("b_drop_occ", {122'h0, b_occ}, {122'h0, 6'h0C});
    chk("b_drop_dout", {32'h0, b_dout}, {32'h0, 32'h0, 32'hB1, 32'h0});
    b_drive(1'b1, 2'd1, 32'hB5, 3'b010);
    chk("b_pp_occ", {122'h0, b_occ}, {122'h0, 6'h0C});
    chk("b_pp_full", {125'h0, b_full}, {125'h0, 3'b010});
    chk("b_pp_dout", {32'h0, b_dout}, {32'h0, 32'h0, 32'hB2, 32'h0});
    b_drive(1'b0, 2'd0, 32'h0, 3'b010);
    chk("b_pop1_dout", {32'h0, b_dout}, {32'h0, 32'h0, 32'hB3, 32'h0});
    chk("b_pop1_nf", {125'h0, b_nf}, {125'h0, 3'b010});
    b_drive(1'b0, 2'd0, 32'h0, 3'b010);
    chk("b_pop2_dout", {32'h0, b_dout}, {32'h0, 32'h0, 32'hB5, 32'h0});
    chk("b_pop2_ne", {125'h0, b_ne}, {125'h0, 3'b010});
    b_drive(1'b0, 2'd0, 32'h0, 3'b010);
    chk("b_pop3_empty", {125'h0, b_empty}, {125'h0, 3'b111});
    chk("b_pop3_dout", {32'h0, b_dout}, 128'h0);
    b_drive(1'b1, 2'd3, 32'hC7, 3'b000);
    chk("b_badvc_occ", {122'h0, b_occ}, {122'h0, 6'h00});
    chk("b_badvc_ovf", {125'h0, b_ovf}, {125'h0, 3'b010});
    chk("b_badvc_unf", {125'h0, b_unf}, {125'h0, 3'b000});
    b_push = 1'b0;

    // Scoreboard run on the default bank with legal random traffic.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] pp;
      logic p;
      int v;
      pp = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        if (sbq[k].size() == 0) pp[k] = 1'b0;
      end
      v = $urandom_range(0, 3);
      p = ($urandom_range(0, 1) == 1) && (sbq[v].size() < 4 || pp[v]);
      a_push = p; a_vc = 2'(v); a_din = $urandom; a_pop = pp;
      step();
      for (int k = 0; k < 4; k++) begin
        if (pp[k]) void'(sbq[k].pop_front());
      end
      if (p) sbq[v].push_back(a_din);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rnd%0d_vc%0d_dout", cyc, k), {96'h0, a_dout[k*32 +: 32]},
            {96'h0, (sbq[k].size() > 0) ? sbq[k][0] : 32'h0});
        chk($sformatf("rnd%0d_vc%0d_occ", cyc, k), {125'h0, a_occ[k*3 +: 3]},
            {125'h0, 3'(sbq[k].size())});
      end
    end
    a_push = 1'b0; a_pop = 4'h0;
    chk("rnd_ovf", {124'h0, a_ovf}, 128'h0);
    chk("rnd_unf", {124'h0, a_unf}, 128'h0);

    // Mid-operation reset discards queued flits on VC0.
    a_push = 1'b1; a_vc = 2'd0; a_din = 32'h11; a_pop = 4'h0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a_din = 32'h12;
    step();
    a_din = 32'h13;
    step();
    a_pop = 4'h2;
    a_push = 1'b0;
    step();
    a_pop = 4'h0;
    chk("pre_rst_occ", {116'h0, a_occ}, {116'h0, 12'h002});
    chk("pre_rst_unf", {124'h0, a_unf}, {124'h0, 4'h2});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_empty", {124'h0, a_empty}, {124'h0, 4'hF});
    chk("mid_rst_occ", {116'h0, a_occ}, 128'h0);
    chk("mid_rst_dout", a_dout, 128'h0);
    chk("mid_rst_unf", {124'h0, a_unf}, 128'h0);
    chk("mid_rst_ovf", {124'h0, a_ovf}, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
